// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to RESET_VAL so the output is quiet coming out of reset.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with sticky frame/overrun (and optional parity) error flags.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err,
    input  logic                 err_clr
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic rxd_s;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    uart_state_t          state, state_n;
    logic [TW-1:0]        tick_cnt, tick_cnt_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 deliver;
    logic                 frame_set;
    logic                 par_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
        end
    end

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        deliver    = 1'b0;
        frame_set  = 1'b0;
        par_set    = 1'b0;
        if (sample_tick) begin
            case (state)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state_n    = ST_START;
                        tick_cnt_n = '0;
                    end
                end
                // Re-check mid start bit; a line already back high was a glitch.
                ST_START: begin
                    if (tick_cnt == TICK_HALF) begin
                        tick_cnt_n = '0;
                        bit_cnt_n  = '0;
                        state_n    = rxd_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt == TICK_FULL) begin
                        tick_cnt_n = '0;
                        shreg_n    = {rxd_s, shreg[DATA_BITS-1:1]};
                        bit_cnt_n  = bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_n = ST_PARITY;
`else
                            state_n = ST_STOP;
`endif
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick_cnt == TICK_FULL) begin
                        tick_cnt_n = '0;
                        par_set    = (rxd_s != ((^shreg) ^ PARITY_ODD));
                        state_n    = ST_STOP;
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_cnt == TICK_FULL) begin
                        tick_cnt_n = '0;
                        state_n    = ST_IDLE;
                        deliver    = rxd_s;
                        frame_set  = !rxd_s;
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Handshake: a word transfers on any clk edge where rx_valid && rx_ready;
    // rx_valid then drops unless a new word is delivered on that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (frame_set)
                frame_err <= 1'b1;
            else if (err_clr)
                frame_err <= 1'b0;

            if (deliver && rx_valid && !rx_ready)
                overrun_err <= 1'b1;
            else if (err_clr)
                overrun_err <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity_err <= 1'b0;
        else if (par_set)
            parity_err <= 1'b1;
        else if (err_clr)
            parity_err <= 1'b0;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..8).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit period (even, >=8).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port sample_tick, input, 1, one-clk pulse at OVERSAMPLE x baud rate, from the baud tick generator.
REQ-006 SHALL have port rxd, input, 1, asynchronous serial line; idle high.
REQ-007 SHALL have port rx_data, output, DATA_BITS, received word, LSB received first.
REQ-008 SHALL have port rx_valid, output, 1, rx_data holds an unconsumed word.
REQ-009 SHALL have port rx_ready, input, 1, consumer accepts word when rx_valid && rx_ready.
REQ-010 SHALL have port frame_err, output, 1, sticky; stop bit sampled low.
REQ-011 SHALL have port overrun_err, output, 1, sticky; frame completed while rx_valid still high.
REQ-012 SHALL have port parity_err, output, 1, sticky; parity mismatch (tied 0 when PARITY_EN undefined).
REQ-013 SHALL have port err_clr, input, 1, one-cycle pulse clearing all sticky error flags.

Function
REQ-014 SHALL pass rxd through a 2-flop synchronizer before any use; all timing below refers to the synchronized signal.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP; counters advance only on cycles with sample_tick=1.
REQ-016 IDLE: on synchronized rxd low at a tick, SHALL go to START with tick counter cleared.
REQ-017 START: after OVERSAMPLE/2 ticks SHALL sample rxd; low -> DATA, high -> IDLE (glitch rejected, no flags set).
REQ-018 DATA: SHALL sample every OVERSAMPLE ticks, shift into bit DATA_BITS-1 moving right, count DATA_BITS bits, then go to PARITY (if enabled) else STOP.
REQ-019 STOP: after OVERSAMPLE ticks SHALL sample rxd; low sets frame_err and the word is discarded; high delivers the word.
REQ-020 Delivery SHALL load rx_data and set rx_valid on the same clk edge; if rx_valid already high, old rx_data is kept, new word dropped, overrun_err set.
REQ-021 rx_valid SHALL clear on the cycle after rx_valid && rx_ready; delivery and acceptance in the same cycle SHALL load the new word and keep rx_valid high.
REQ-022 After STOP the FSM SHALL return to IDLE immediately, enabling back-to-back frames with a single stop bit.
REQ-023 err_clr SHALL have lower priority than a same-cycle error set (flag remains 1).
REQ-024 Tick counter width SHALL be clog2(OVERSAMPLE); bit counter width clog2(DATA_BITS+1); no wrap-around beyond terminal counts.

Reset
REQ-025 rst SHALL asynchronously force state IDLE, counters 0, rx_data 0, rx_valid 0, all error flags 0, synchronizer flops 1.
REQ-026 rst asserted mid-frame SHALL abandon the frame with no delivery or flag after release.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined, SHALL add parameter PARITY_ODD (default 0) and PARITY state: sample one bit OVERSAMPLE ticks after last data bit; mismatch sets parity_err, word still delivered.
REQ-028 Without UART_RX_PARITY_EN, SHALL omit PARITY state and logic; parity_err constant 0.

Structure
REQ-029 SHALL place the state enum typedef, default OVERSAMPLE and DATA_BITS constants in shared package uart_pkg.
REQ-030 SHALL instantiate one sub-module, sync2, a 2-flop synchronizer with reset value parameter.

Verification (OVERSAMPLE=16, sample_tick every 4 clks, rx_ready=1 unless stated)
REQ-031 Frame 0xA5, stop high -> rx_data=0xA5, rx_valid one cycle, all flags 0.
REQ-032 rxd low for 4 ticks then high -> FSM returns to IDLE, rx_valid never asserts.
REQ-033 Frame 0x3C with stop bit low -> frame_err=1, rx_valid stays 0; err_clr -> frame_err=0.
REQ-034 rx_ready=0, frames 0x11 then 0x22 -> rx_data=0x11, overrun_err=1; rx_ready=1 -> rx_valid falls next cycle.
REQ-035 UART_RX_PARITY_EN, PARITY_ODD=0, 0x07 with parity bit 0 -> rx_data=0x07, parity_err=1.
REQ-036 rst pulse during DATA bit 3 of 0xFF, then frame 0x5A -> only 0x5A delivered, flags 0.
